// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for serial_subtractor (ovf member only with SERIAL_SUB_OVF_EN)
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  ready, busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output ready, busy, done, diff, bout, ovf
   );
`else
   modport master (
      output start, a, b, bin,
      input  ready, busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin,
      output ready, busy, done, diff, bout
   );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B-BIN subtractor, LSB first; optional signed overflow via SERIAL_SUB_OVF_EN
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_subtractor_if.slave  s
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
   logic             msb_bin_q, msb_bin_d;
   logic             ovf_q, ovf_d;
`endif

   logic cell_x;
   logic cell_y;
   logic cell_d;
   logic cell_br;

   // Single full-subtractor cell working on the current LSBs and the stored borrow
   always_comb begin
      cell_x  = a_sh_q[0];
      cell_y  = b_sh_q[0];
      cell_d  = cell_x ^ cell_y ^ br_q;
      cell_br = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & br_q);
   end

   // Next-state and datapath control; results are committed while leaving DONE
   // so done, diff and bout become visible together on the following cycle
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      msb_bin_d = msb_bin_q;
      ovf_d     = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (s.start) begin
               a_sh_d  = s.a;
               b_sh_d  = s.b;
               br_d    = s.bin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = cell_br;
            res_d  = {cell_d, res_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_SUB_OVF_EN
               // Borrow entering the sign bit; compared with the final borrow for overflow
               msb_bin_d = br_q;
`endif
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            diff_d  = res_q;
            bout_d  = br_q;
            done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            ovf_d   = msb_bin_q ^ br_q;
`endif
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         done_q  <= done_d;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Signed-overflow capture registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msb_bin_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         msb_bin_q <= msb_bin_d;
         ovf_q     <= ovf_d;
      end
   end

   assign s.ovf = ovf_q;
`endif

   assign s.ready = (state_q == S_IDLE);
   assign s.busy  = (state_q == S_RUN);
   assign s.done  = done_q;
   assign s.diff  = diff_q;
   assign s.bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(W)) sif ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (sif)
   );

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } exp_t;

   exp_t         sb[$];
   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] held_diff = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operands
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      exp_t m;
      int   ia;
      int   ib;
      int   ibin;
      int   r;
      int   sa;
      int   sbv;
      int   sr;
      ia     = int'(a);
      ib     = int'(b);
      ibin   = bin ? 1 : 0;
      r      = ia - ib - ibin;
      if (r < 0) r = r + (1 << W);
      m.diff = W'(r);
      m.bout = (ia < ib + ibin);
      sa     = a[W-1] ? ia - (1 << W) : ia;
      sbv    = b[W-1] ? ib - (1 << W) : ib;
      sr     = sa - sbv - ibin;
      m.ovf  = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
      return m;
   endfunction

   // Monitor: every done pulse is matched against the oldest expected result
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && sif.done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
         end else begin
            e = sb.pop_front();
            check("diff", 64'(sif.diff), 64'(e.diff));
            check("bout", 64'(sif.bout), 64'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
            check("ovf", 64'(sif.ovf), 64'(e.ovf));
`endif
            held_diff = e.diff;
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!sif.ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!sif.ready) begin
         $display("FAIL ready_timeout: got ready=0 expected 1");
         errors++;
         checks++;
      end
   endtask

   // One operation from a negedge; optionally pokes start mid-RUN and checks timing
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit poke, input bit timing);
      int busy_n;
      int done_at;
      wait_ready();
      sif.a     = a;
      sif.b     = b;
      sif.bin   = bin;
      sif.start = 1'b1;
      @(posedge clk);
      sb.push_back(model(a, b, bin));
      #1;
      sif.start = 1'b0;
      sif.a     = W'($urandom);
      sif.b     = W'($urandom);
      sif.bin   = 1'($urandom);
      busy_n    = sif.busy ? 1 : 0;
      done_at   = 0;
      for (int e = 1; e <= W + 4 && done_at == 0; e++) begin
         @(posedge clk);
         #1;
         if (sif.done) done_at = e;
         if (sif.busy) busy_n++;
         if (e == 3) begin
            check("diff_held", 64'(sif.diff), 64'(held_diff));
            if (poke) begin
               sif.start = 1'b1;
               sif.a     = W'(1);
               sif.b     = W'(1);
               sif.bin   = 1'b0;
            end
         end
         if (e == 4) sif.start = 1'b0;
         if (e == W / 2) check("ready_in_run", 64'(sif.ready), 64'd0);
      end
      check("done_seen", 64'(done_at != 0), 64'd1);
      if (timing) begin
         check("latency", 64'(done_at), 64'(W + 1));
         check("busy_cycles", 64'(busy_n), 64'(W));
      end
      @(negedge clk);
   endtask

   task automatic reset_mid_run();
      bit saw_done;
      int done_at;
      exp_t dropped;
      wait_ready();
      sif.a     = W'(77);
      sif.b     = W'(12);
      sif.bin   = 1'b1;
      sif.start = 1'b1;
      @(posedge clk);
      sb.push_back(model(W'(77), W'(12), 1'b1));
      #1;
      sif.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      dropped   = sb.pop_back();
      held_diff = '0;
      check("rst_ready", 64'(sif.ready), 64'd1);
      check("rst_busy", 64'(sif.busy), 64'd0);
      check("rst_done", 64'(sif.done), 64'd0);
      check("rst_diff", 64'(sif.diff), 64'd0);
      check("rst_bout", 64'(sif.bout), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", 64'(sif.ovf), 64'd0);
`endif
      saw_done = 1'b0;
      for (int e = 0; e < W + 4; e++) begin
         @(posedge clk);
         #1;
         if (sif.done) saw_done = 1'b1;
      end
      check("no_done_after_reset", 64'(saw_done), 64'd0);
      sif.a     = W'(9);
      sif.b     = W'(3);
      sif.bin   = 1'b0;
      sif.start = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      sb.push_back(model(W'(9), W'(3), 1'b0));
      #1;
      sif.start = 1'b0;
      check("accept_after_reset", 64'(sif.busy), 64'd1);
      done_at = 0;
      for (int e = 1; e <= W + 4 && done_at == 0; e++) begin
         @(posedge clk);
         #1;
         if (sif.done) done_at = e;
      end
      check("done_after_reset", 64'(done_at), 64'(W + 1));
      @(negedge clk);
   endtask

   // Start held high: accepts must land every W+2 cycles
   task automatic back_to_back(input int n_ops);
      time          last_t;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbin;
      last_t    = 0;
      sif.start = 1'b1;
      for (int i = 0; i < n_ops; i++) begin
         wait_ready();
         ra      = W'($urandom);
         rb      = W'($urandom);
         rbin    = 1'($urandom);
         sif.a   = ra;
         sif.b   = rb;
         sif.bin = rbin;
         @(posedge clk);
         sb.push_back(model(ra, rb, rbin));
         if (i > 0) check("accept_interval", 64'(($time - last_t) / 10), 64'(W + 2));
         last_t = $time;
         @(negedge clk);
      end
      sif.start = 1'b0;
      repeat (W + 4) @(negedge clk);
   endtask

   initial begin
      sif.start = 1'b0;
      sif.a     = '0;
      sif.b     = '0;
      sif.bin   = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("init_ready", 64'(sif.ready), 64'd1);
      check("init_busy", 64'(sif.busy), 64'd0);
      check("init_done", 64'(sif.done), 64'd0);
      check("init_diff", 64'(sif.diff), 64'd0);
      check("init_bout", 64'(sif.bout), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("init_ovf", 64'(sif.ovf), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      do_op(W'(200), W'(55), 1'b0, 1'b0, 1'b1);
      do_op(W'(5), W'(10), 1'b0, 1'b0, 1'b1);
      do_op(W'(0), W'(0), 1'b1, 1'b0, 1'b0);
      do_op(W'(200), W'(55), 1'b1, 1'b1, 1'b1);
      do_op(W'(8'h80), W'(8'h01), 1'b0, 1'b0, 1'b0);
      do_op(W'(8'h10), W'(8'h01), 1'b0, 1'b0, 1'b0);
      do_op(W'(8'h7F), W'(8'hFF), 1'b1, 1'b0, 1'b0);
      do_op(W'(8'hFF), W'(8'hFF), 1'b0, 1'b0, 1'b0);
      reset_mid_run();
      back_to_back(1000);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
